// File: rtl/segment_cmd_scheduler.sv
// segment_cmd_scheduler: merges user and automatic commands into spaced single-cycle driver strobes
module segment_cmd_scheduler #(
  parameter int AUTO_PERIOD = 50_000_000,
  parameter int HOLDOFF     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 26
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic                          auto_en,
  input  logic                          usr_next,
  input  logic                          usr_mode,
  output logic                          next_segment_re,
  output logic                          change_mode_re,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count_n;
  logic [AW+1:0] free;
  logic [HW-1:0] hcnt;
  logic [CNT_W-1:0] timer;
  logic [1:0] nwr;
  logic pop, head, tick, wm, wn, wa;
  // Queue admission (MODE before NEXT, pop frees a slot first) and FSM next state
  always_comb begin
    pop = state == IDLE && fifo_level != '0;
    head = mem[rd_ptr];
    free = (AW+2)'(FIFO_DEPTH) - (AW+2)'(fifo_level) + (AW+2)'(pop);
    tick = auto_en && timer == CNT_W'(AUTO_PERIOD - 1);
    wm = usr_mode && free != '0;
    wn = usr_next && free > (AW+2)'(wm);
    wa = tick && fifo_level == '0 && !usr_mode && !usr_next;
    nwr = 2'(wm) + 2'(wn) + 2'(wa);
    count_n = fifo_level + (AW+1)'(nwr) - (AW+1)'(pop);
    state_n = state == IDLE  ? (pop ? ISSUE : IDLE) :
              state == ISSUE ? HOLD :
              hcnt == HW'(HOLDOFF - 1) ? IDLE : HOLD;
  end
  // State, pointers, timer and registered outputs
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_level <= '0;
      hcnt <= '0;
      timer <= '0;
      next_segment_re <= 1'b0;
      change_mode_re <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(nwr);
      fifo_level <= count_n;
      hcnt <= state == HOLD ? hcnt + 1'b1 : '0;
      timer <= (!auto_en || usr_next || usr_mode || tick) ? '0 : timer + 1'b1;
      next_segment_re <= pop && !head;
      change_mode_re <= pop && head;
      busy <= state_n != IDLE || count_n != '0;
      overflow <= overflow || (usr_mode && !wm) || (usr_next && !wn);
    end
  end
  // Queue storage: the first write of a cycle is MODE when present, any second write is NEXT
  always_ff @(posedge clk) begin
    if (nwr != 2'd0) mem[wr_ptr] <= wm;
    if (nwr == 2'd2) mem[wr_ptr + AW'(1)] <= 1'b0;
  end
endmodule

// File: tb/tb_segment_cmd_scheduler.sv
// tb_segment_cmd_scheduler: queue-level reference model with a decoupled scoreboard monitor
module tb_segment_cmd_scheduler;
  localparam int P = 8, H = 4, D = 4;
  logic clk = 1'b0, sync_reset = 1'b1, auto_en = 1'b0, usr_next = 1'b0, usr_mode = 1'b0;
  logic nxt, mode, busy, overflow;
  logic [2:0] fifo_level;
  typedef struct {bit cmd; int e;} pulse_t;
  typedef struct {int e; int lvl; bit busy; bit ovf;} stat_t;
  pulse_t pq[$];
  stat_t sq[$];
  bit q[$];
  int cyc = 0, total = 0, bad = 0, tmr = 0, ready = 0;
  bit ovf = 1'b0;

  segment_cmd_scheduler #(.AUTO_PERIOD(P), .HOLDOFF(H), .FIFO_DEPTH(D), .CNT_W(4)) dut (
    .clk(clk), .sync_reset(sync_reset), .auto_en(auto_en), .usr_next(usr_next),
    .usr_mode(usr_mode), .next_segment_re(nxt), .change_mode_re(mode), .busy(busy),
    .overflow(overflow), .fifo_level(fifo_level));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc - 1, act, exp);
    end
  endtask

  // One clock of stimulus; the model predicts what the DUT shows right after the coming edge
  task automatic step(input bit r, input bit a, input bit n, input bit m);
    int e;
    bit pre_empty, tk;
    @(negedge clk);
    sync_reset = r; auto_en = a; usr_next = n; usr_mode = m;
    e = cyc;
    if (r) begin
      q.delete(); pq.delete(); tmr = 0; ovf = 0; ready = 0;
      sq.push_back('{e, 0, 1'b0, 1'b0});
      return;
    end
    pre_empty = q.size() == 0;
    if (!pre_empty && e >= ready) begin
      pq.push_back('{q[0], e});
      void'(q.pop_front());
      ready = e + H + 2;
    end
    tk = a && tmr == P - 1;
    if (m) begin if (q.size() < D) q.push_back(1'b1); else ovf = 1'b1; end
    if (n) begin if (q.size() < D) q.push_back(1'b0); else ovf = 1'b1; end
    if (tk && pre_empty && !n && !m) q.push_back(1'b0);
    tmr = (!a || n || m || tk) ? 0 : tmr + 1;
    sq.push_back('{e, q.size(), q.size() > 0 || e < ready - 1, ovf});
  endtask

  task automatic idle(input int k, input bit a);
    repeat (k) step(1'b0, a, 1'b0, 1'b0);
  endtask

  // Monitor: pops a pulse expectation whenever a command strobe appears, and per-edge status
  initial begin
    int e;
    pulse_t p;
    stat_t s;
    forever begin
      @(posedge clk);
      #1;
      e = cyc - 1;
      check("both_high", int'(nxt && mode), 0);
      if (nxt || mode) begin
        if (pq.size() == 0) check("unexpected_pulse", int'({mode, nxt}), 0);
        else begin
          p = pq.pop_front();
          check("pulse_cmd", int'({mode, nxt}), p.cmd ? 2 : 1);
          check("pulse_edge", e, p.e);
        end
      end
      while (pq.size() > 0 && pq[0].e < e) begin
        check("missed_pulse_edge", e, pq[0].e);
        void'(pq.pop_front());
      end
      if (sq.size() > 0 && sq[0].e == e) begin
        s = sq.pop_front();
        check("fifo_level", int'(fifo_level), s.lvl);
        check("busy", int'(busy), int'(s.busy));
        check("overflow", int'(overflow), int'(s.ovf));
      end
    end
  end

  initial begin
    bit a;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(12, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(16, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(40, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    idle(30, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(25, 1'b1);
    for (int i = 0; i < 20 && tmr != P - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(20, 1'b1);
    a = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 59) == 0) a = ~a;
      step($urandom_range(0, 199) == 0, a, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    idle(30, 1'b0);
    @(posedge clk);
    #2;
    check("pending_pulses", pq.size(), 0);
    check("pending_status", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
